main_mem_resp: RTL and testbench

- Main-memory responder model for the cache's line-granular memory port; it is the other end of the cache's mm_* interface.
- Accepts line-fill reads and line-eviction writes, 32B/256b per transaction.
- Holds a backing store of 2^ADDR_WIDTH lines and answers with a one-cycle mm_valid pulse after a programmable latency.
- Used as the memory behind the cache in block and system benches; it is also synthesizable as an on-chip line store.

---
 rtl/main_mem_resp.sv | 226 ++++++++++++++++++++++
 tb/tb_main_mem_resp.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_resp.sv
// main_mem_resp: line-granular main-memory responder for the cache mm_* port.
// Holds 2^ADDR_WIDTH lines of LINE_BITS each. Reads and writes complete with a
// one-cycle mm_valid pulse, then a one-cycle recover before the next request.
//
// Ports:
//   clk, reset   : clock (posedge), synchronous active-low reset
//   mm_a         : byte address; line index = mm_a[ADDR_WIDTH+4:5]
//   mm_wd        : eviction (write) data
//   mm_write     : write command, held until mm_valid
//   mm_read      : read command, held until mm_valid
//   mm_rd        : fill data, registered, holds last read value
//   mm_valid     : one-cycle completion pulse
//   mm_busy      : high whenever the FSM is not idle
//   mm_err       : sticky flag, set by read and write both high in IDLE
//   rd_count, wr_count, err_count : saturating statistics (MM_STATS_EN only)
//
// Optional feature macro: MM_STATS_EN adds the statistics counters and ports.
//
// Timing: a request seen in IDLE during cycle c produces mm_valid in cycle
// c+LATENCY. LATENCY=1 jumps straight from IDLE to RESP.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for a command; both commands high sets mm_err
// RD_WAIT    | read accepted, counting down read latency
// WR_WAIT    | write accepted, counting down write latency
// RESP       | mm_valid high; read data presented / write just committed
// RECOVER    | inputs ignored while initiator drops its command
module main_mem_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LINE_BITS  = 256,
  parameter int RD_LATENCY = 8,
  parameter int WR_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          mm_a,
  input  logic [LINE_BITS-1:0] mm_wd,
  input  logic                 mm_write,
  input  logic                 mm_read,
  output logic [LINE_BITS-1:0] mm_rd,
  output logic                 mm_valid,
  output logic                 mm_busy,
  output logic                 mm_err
`ifdef MM_STATS_EN
  ,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
  output logic [7:0]           err_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_RESP,
    ST_RECOVER
  } state_t;

  // Wait-state counters are loaded with LATENCY-2: one cycle is spent in the
  // IDLE acceptance cycle's edge, one on the edge entering RESP.
  localparam logic [7:0] RD_LOAD = (RD_LATENCY > 1) ? 8'(RD_LATENCY - 2) : 8'd0;
  localparam logic [7:0] WR_LOAD = (WR_LATENCY > 1) ? 8'(WR_LATENCY - 2) : 8'd0;

  logic [LINE_BITS-1:0] store [2**ADDR_WIDTH];

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [LINE_BITS-1:0]  wd_q, wd_d;
  logic [LINE_BITS-1:0]  mm_rd_q, mm_rd_d;
  logic                  mm_valid_q, mm_valid_d;
  logic                  mm_busy_q, mm_busy_d;
  logic                  mm_err_q, mm_err_d;

  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [LINE_BITS-1:0]  wr_data;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  ill_cmd;

  // Offset and alias bits of the address are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mm_a[31:ADDR_WIDTH+5], mm_a[4:0]};

  assign req_idx = mm_a[ADDR_WIDTH+4:5];

`ifdef MM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [7:0]  err_count_q, err_count_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    mm_rd_d  = mm_rd_q;
    mm_err_d = mm_err_q;
    wr_en    = 1'b0;
    wr_idx   = idx_q;
    wr_data  = wd_q;
    rd_fire  = 1'b0;
    wr_fire  = 1'b0;
    ill_cmd  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mm_read && mm_write) begin
          mm_err_d = 1'b1;
          ill_cmd  = 1'b1;
        end else if (mm_read) begin
          idx_d = req_idx;
          if (RD_LATENCY == 1) begin
            state_d = ST_RESP;
            mm_rd_d = store[req_idx];
            rd_fire = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = RD_LOAD;
          end
        end else if (mm_write) begin
          idx_d = req_idx;
          wd_d  = mm_wd;
          if (WR_LATENCY == 1) begin
            state_d = ST_RESP;
            wr_en   = 1'b1;
            wr_idx  = req_idx;
            wr_data = mm_wd;
            wr_fire = 1'b1;
          end else begin
            state_d = ST_WR_WAIT;
            cnt_d   = WR_LOAD;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RESP;
          mm_rd_d = store[idx_q];
          rd_fire = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RESP;
          wr_en   = 1'b1;
          wr_fire = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP:    state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    mm_valid_d = (state_d == ST_RESP);
    mm_busy_d  = (state_d != ST_IDLE);
  end

`ifdef MM_STATS_EN
  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    if (rd_fire && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
    if (wr_fire && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
    if (ill_cmd && err_count_q != 8'hFF)   err_count_d = err_count_q + 8'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      wd_q       <= '0;
      mm_rd_q    <= '0;
      mm_valid_q <= 1'b0;
      mm_busy_q  <= 1'b0;
      mm_err_q   <= 1'b0;
`ifdef MM_STATS_EN
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
      err_count_q <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wd_q       <= wd_d;
      mm_rd_q    <= mm_rd_d;
      mm_valid_q <= mm_valid_d;
      mm_busy_q  <= mm_busy_d;
      mm_err_q   <= mm_err_d;
`ifdef MM_STATS_EN
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
`endif
    end
  end

  // Store is never cleared; a reset on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (reset && wr_en) store[wr_idx] <= wr_data;
  end

  assign mm_rd    = mm_rd_q;
  assign mm_valid = mm_valid_q;
  assign mm_busy  = mm_busy_q;
  assign mm_err   = mm_err_q;
`ifdef MM_STATS_EN
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_main_mem_resp.sv
module tb_main_mem_resp;
  localparam int AW     = 10;
  localparam int RD_LAT = 8;
  localparam int WR_LAT = 4;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [31:0]  a;
  logic [255:0] wd;
  logic         wr, rd;
  logic [255:0] rdata;
  logic         valid, busy, err;

  logic [31:0]  f_a;
  logic [255:0] f_wd;
  logic         f_wr, f_rd;
  logic [255:0] f_rdata;
  logic         f_valid, f_busy, f_err;

`ifdef MM_STATS_EN
  logic [15:0] rd_count, wr_count, f_rd_count, f_wr_count;
  logic [7:0]  err_count, f_err_count;
`endif

  main_mem_resp #(.ADDR_WIDTH(AW), .LINE_BITS(256), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) u_dut (
    .clk(clk), .reset(reset), .mm_a(a), .mm_wd(wd), .mm_write(wr), .mm_read(rd),
    .mm_rd(rdata), .mm_valid(valid), .mm_busy(busy), .mm_err(err)
`ifdef MM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  main_mem_resp #(.ADDR_WIDTH(AW), .LINE_BITS(256), .RD_LATENCY(1), .WR_LATENCY(1)) u_fast (
    .clk(clk), .reset(reset), .mm_a(f_a), .mm_wd(f_wd), .mm_write(f_wr), .mm_read(f_rd),
    .mm_rd(f_rdata), .mm_valid(f_valid), .mm_busy(f_busy), .mm_err(f_err)
`ifdef MM_STATS_EN
    , .rd_count(f_rd_count), .wr_count(f_wr_count), .err_count(f_err_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one entry per line index, filled by completed writes.
  logic [255:0] mem_m [int];
  int           lines_w [$];
  logic [255:0] last_rd;
  int           rd_n, wr_n, err_n;

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr / 32) % (2 ** AW));
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at a negedge while the DUT is idle; returns at a negedge, idle again.
  task automatic txn(input bit is_wr, input logic [31:0] addr, input logic [255:0] data);
    int  n;
    bit  seen;
    int  exp_lat;
    int  k;
    exp_lat = is_wr ? WR_LAT : RD_LAT;
    k = idx_of(addr);
    check("pre_busy", busy, 0);
    a = addr; wd = data; wr = is_wr; rd = !is_wr;
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (valid) seen = 1'b1;
    end
    check(is_wr ? "wr_latency" : "rd_latency", 256'(n), 256'(exp_lat));
    wr = 1'b0; rd = 1'b0;
    if (is_wr) begin
      if (!mem_m.exists(k)) lines_w.push_back(k);
      mem_m[k] = data;
      wr_n++;
    end else begin
      last_rd = mem_m.exists(k) ? mem_m[k] : 'x;
      rd_n++;
    end
    check(is_wr ? "rd_hold_on_wr" : "rd_data", rdata, last_rd);
    @(posedge clk); #1;
    check("recover_valid", valid, 0);
    check("recover_busy", busy, 1);
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    @(negedge clk);
  endtask

`ifdef MM_STATS_EN
  task automatic check_stats();
    check("rd_count", rd_count, 256'(rd_n));
    check("wr_count", wr_count, 256'(wr_n));
    check("err_count", err_count, 256'(err_n));
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_first, t_second, cyc, npulse;
    logic busy_after, data_ok;
    logic [255:0] pat;
    int nvalid;

    reset = 1'b0;
    a = '0; wd = '0; wr = 1'b0; rd = 1'b0;
    f_a = '0; f_wd = '0; f_wr = 1'b0; f_rd = 1'b0;
    last_rd = '0; rd_n = 0; wr_n = 0; err_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_rd", rdata, 0);

    // Minimum-latency DUT: write, then hold read across two requests.
    pat = rand_line();
    f_a = 32'h0000_0060; f_wd = pat; f_wr = 1'b1;
    @(posedge clk); #1;
    check("fast_wr_valid", f_valid, 1);
    f_wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    f_rd = 1'b1;
    cyc = 0; npulse = 0; t_first = -1; t_second = -1; busy_after = 1'b0; data_ok = 1'b1;
    while (npulse < 2 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == t_first + 1) busy_after = f_busy;
      if (f_valid) begin
        npulse++;
        if (f_rdata !== pat) data_ok = 1'b0;
        if (npulse == 1) t_first = cyc; else t_second = cyc;
      end
    end
    f_rd = 1'b0;
    check("fast_rd_latency", 256'(t_first), 256'(1));
    check("fast_b2b_spacing", 256'(t_second - t_first), 256'(3));
    check("fast_recover_busy", busy_after, 1);
    check("fast_rd_data", data_ok, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Write then read the same line.
    txn(1'b1, 32'h0000_0120, {8{32'hDEAD_BEEF}});
    txn(1'b0, 32'h0000_0120, 256'd0);
    check("wr_rd_same", rdata, {8{32'hDEAD_BEEF}});

    // Aliasing and byte-offset ignore.
    pat = rand_line();
    txn(1'b1, 32'h0000_0040, pat);
    txn(1'b0, 32'h0000_805F, 256'd0);
    check("alias_rd", rdata, pat);

    // Illegal command for two cycles in IDLE.
    a = 32'h0000_0120; wd = '0; rd = 1'b1; wr = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
      check("ill_busy", busy, 0);
    end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    err_n += 2;
    check("ill_err", err, 1);
    check("ill_no_valid", 256'(nvalid), 256'(0));
`ifdef MM_STATS_EN
    check_stats();
`endif
    txn(1'b0, 32'h0000_0120, 256'd0);
    check("ill_store_kept", rdata, {8{32'hDEAD_BEEF}});
    check("err_sticky", err, 1);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      int ln;
      logic [31:0] ad;
      if (lines_w.size() == 0 || $urandom_range(0, 1) == 0) begin
        ln = $urandom_range(0, 7) * 37;
        ad = ($urandom & 32'hFFFF_8000) | (32'(ln) << 5) | 32'($urandom_range(0, 31));
        txn(1'b1, ad, rand_line());
      end else begin
        ln = lines_w[$urandom_range(0, lines_w.size() - 1)];
        ad = ($urandom & 32'hFFFF_8000) | (32'(ln) << 5) | 32'($urandom_range(0, 31));
        txn(1'b0, ad, 256'd0);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check("err_sticky_end", err, 1);
`ifdef MM_STATS_EN
    check_stats();
`endif

    // Reset during an in-flight write.
    txn(1'b1, 32'h0000_0200, {8{32'h1111_1111}});
    a = 32'h0000_0200; wd = {8{32'h2222_2222}}; wr = 1'b1;
    nvalid = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    @(negedge clk);
    reset = 1'b0; wr = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    @(negedge clk);
    check("rst_mid_no_valid", 256'(nvalid), 256'(0));
    check("rst2_err", err, 0);
    check("rst2_busy", busy, 0);
    check("rst2_rd", rdata, 0);
    last_rd = '0; rd_n = 0; wr_n = 0; err_n = 0;
`ifdef MM_STATS_EN
    check_stats();
`endif
    txn(1'b0, 32'h0000_0200, 256'd0);
    check("rst_wr_not_commit", rdata, {8{32'h1111_1111}});
`ifdef MM_STATS_EN
    check_stats();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
